// File: rtl/persiana_pkg.sv
`default_nettype none
// ============================================================================
// persiana_pkg : shared state, fault and direction encodings for the blind
//                motor driver.
// Rev 1.0
// ============================================================================
package persiana_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_COAST = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_TIMEOUT = 2'b01;
  localparam logic [1:0] FLT_LIMIT   = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/persiana_timer.sv
`default_nettype none
// ============================================================================
// persiana_timer : saturating CW-bit counter with clear, enable and a
//                  terminal-count compare against a selectable limit.
// Rev 1.0
// ============================================================================
module persiana_timer #(
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] limit_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {CW{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = en_i && (cnt_q == limit_i);

endmodule
`default_nettype wire

// File: rtl/persiana_motor_driver.sv
`default_nettype none
// ============================================================================
// persiana_motor_driver : dead-time, coast, limit interlock and run watchdog
//                         between the position FSM and the motor power stage.
// Rev 1.0
// ============================================================================
module persiana_motor_driver
  import persiana_pkg::*;
#(
  parameter int DEAD_CYCLES = 4,
  parameter int MAX_RUN     = 1000,
  parameter int CW          = 16
) (
  input  logic       Reloj,
  input  logic       reset,
  input  logic       subir,
  input  logic       bajar,
  input  logic       Ssup,
  input  logic       Sinf,
  input  logic       clr_fault,
  output logic       motor_en,
  output logic       motor_dir,
  output logic       en_marcha,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [CW-1:0] C_DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] C_RUN_LAST  = CW'(MAX_RUN - 1);

  state_e      state_q, state_d;
  logic        motor_en_q, motor_dir_q, motor_dir_d;
  logic        en_marcha_q, fault_q;
  logic [1:0]  fault_code_q, fault_code_d;

  logic        w_up_req, w_dn_req, w_conflict, w_tgt_lost;
  logic        w_tmr_clr, w_tmr_en, w_tc;
  logic [CW-1:0] w_limit, w_cnt;

  assign w_up_req   = subir & ~bajar;
  assign w_dn_req   = bajar & ~subir;
  assign w_conflict = Ssup & Sinf;
  // Request gone, reversed, or the switch we are heading for has closed.
  assign w_tgt_lost = motor_dir_q ? (~w_up_req | Ssup) : (~w_dn_req | Sinf);

  always_comb begin
    state_d      = state_q;
    motor_dir_d  = motor_dir_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_IDLE: begin
        if (w_up_req && !Ssup) begin
          state_d     = ST_ARM;
          motor_dir_d = DIR_UP;
        end else if (w_dn_req && !Sinf) begin
          state_d     = ST_ARM;
          motor_dir_d = DIR_DN;
        end
      end
      ST_ARM: begin
        if (w_tgt_lost)  state_d = ST_IDLE;
        else if (w_tc)   state_d = ST_RUN;
      end
      ST_RUN: begin
        if (w_tgt_lost) begin
          state_d = ST_COAST;
        end else if (w_tc) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_TIMEOUT;
        end
      end
      ST_COAST: begin
        if (w_tc) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (clr_fault && !w_up_req && !w_dn_req && !w_conflict) begin
          state_d      = ST_IDLE;
          fault_code_d = FLT_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (w_conflict && (state_q != ST_FAULT)) begin
      state_d      = ST_FAULT;
      fault_code_d = FLT_LIMIT;
    end
  end

  assign w_tmr_clr = (state_d != state_q);
  assign w_tmr_en  = (state_q == ST_ARM) || (state_q == ST_RUN) || (state_q == ST_COAST);
  assign w_limit   = (state_q == ST_RUN) ? C_RUN_LAST : C_DEAD_LAST;

  persiana_timer #(
    .CW (CW)
  ) u_timer (
    .clk_i   (Reloj),
    .rst_i   (reset),
    .clr_i   (w_tmr_clr),
    .en_i    (w_tmr_en),
    .limit_i (w_limit),
    .cnt_o   (w_cnt),
    .tc_o    (w_tc)
  );

  // Outputs are registered from the next state so they change with it.
  always_ff @(posedge Reloj or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      motor_en_q   <= 1'b0;
      motor_dir_q  <= DIR_DN;
      en_marcha_q  <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FLT_NONE;
    end else begin
      state_q      <= state_d;
      motor_en_q   <= (state_d == ST_RUN);
      motor_dir_q  <= motor_dir_d;
      en_marcha_q  <= (state_d == ST_ARM) || (state_d == ST_RUN) || (state_d == ST_COAST);
      fault_q      <= (state_d == ST_FAULT);
      fault_code_q <= fault_code_d;
    end
  end

  assign motor_en   = motor_en_q;
  assign motor_dir  = motor_dir_q;
  assign en_marcha  = en_marcha_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule
`default_nettype wire

// File: doc/persiana_motor_driver.md
Name: persiana_motor_driver

Overview:
- Downstream stage of the blind controller: consumes the subir/bajar motion requests from the position FSM and drives the motor power stage.
- Adds a dead-time before every energisation and a coast period after every stop.
- Adds limit-switch interlocking and a run-timeout watchdog.
- Latches faults for the supervisor; outputs are registered so the power stage never sees glitches.

Parameters:
- DEAD_CYCLES, 4, clock cycles motor stays de-energised before start and after stop (>=1)
- MAX_RUN, 1000, maximum consecutive energised cycles before a timeout fault (>=2)
- CW, 16, counter width; must satisfy 2^CW > max(DEAD_CYCLES, MAX_RUN)

Ports:
- Reloj  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- subir  input  1  raise request from position FSM
- bajar  input  1  lower request from position FSM
- Ssup  input  1  upper limit switch, 1 = fully open
- Sinf  input  1  lower limit switch, 1 = fully closed
- clr_fault  input  1  supervisor fault clear
- motor_en  output  1  power-stage enable (registered)
- motor_dir  output  1  1 = up, 0 = down (registered)
- en_marcha  output  1  1 whenever state != IDLE and != FAULT
- fault  output  1  latched fault flag
- fault_code  output  2  00 none, 01 run timeout, 10 limit-switch conflict

Behaviour:
- Clock and reset: one clock (Reloj); reset is asynchronous and active-high. While reset = 1, outputs are forced immediately (no clock needed): state = IDLE, cnt = 0, motor_en = 0, motor_dir = 0, fault = 0, fault_code = 00.
- Command decode:
  - up_req = subir & ~bajar
  - dn_req = bajar & ~subir
  - subir = bajar = 1 is treated as no request.
- States: IDLE, ARM, RUN, COAST, FAULT. All outputs are registered.
- IDLE:
  - motor_en = 0; motor_dir holds its last value; cnt = 0.
  - up_req & ~Ssup -> ARM with dir = 1.
  - dn_req & ~Sinf -> ARM with dir = 0.
  - A request toward a switch that is already active is ignored.
- ARM:
  - motor_en = 0; motor_dir = target direction.
  - cnt increments every cycle; after DEAD_CYCLES cycles in ARM -> RUN.
  - Abort to IDLE if the request drops, flips to the opposite direction, or the target limit switch activates.
- RUN:
  - motor_en = 1; motor_en is high from the first RUN cycle.
  - cnt restarts at 0 on entry.
  - Exit to COAST if the request drops, the opposite request appears, or the target limit switch goes high. motor_en falls on the edge after the condition is sampled (1-cycle latency).
  - Timeout: if cnt reaches MAX_RUN-1 with no exit condition -> FAULT, fault_code = 01. motor_en is therefore high for at most MAX_RUN cycles.
  - Priority: an exit condition beats the timeout in the same cycle (go to COAST, no fault).
- COAST:
  - motor_en = 0; motor_dir held.
  - Lasts DEAD_CYCLES cycles, then -> IDLE. Inputs are ignored during COAST.
  - A reversal therefore costs COAST + ARM = 2*DEAD_CYCLES de-energised cycles minimum.
- Limit-switch conflict: Ssup & Sinf = 1 in any state except FAULT -> FAULT with fault_code = 10 on the next edge. This overrides every other transition.
- FAULT:
  - motor_en = 0; fault = 1; fault_code held.
  - Leaves to IDLE only when clr_fault = 1 AND no request is present (up_req = dn_req = 0) AND Ssup & Sinf = 0.
  - Fault flags clear on that same edge.
- Counter arithmetic: unsigned CW bits, never wraps. It is compared against DEAD_CYCLES-1 and MAX_RUN-1 and reset on every state change.
- Reset mid-operation: motor_en drops asynchronously. After release the block starts in IDLE; a held request re-arms with a full dead-time.

Decomposition:
- Shared package persiana_pkg:
  - state encoding localparams: ST_IDLE, ST_ARM, ST_RUN, ST_COAST, ST_FAULT
  - fault codes: FLT_NONE, FLT_TIMEOUT, FLT_LIMIT
  - direction constants: DIR_UP = 1, DIR_DN = 0
- One natural sub-module, persiana_timer: a CW-bit counter with clear, enable and terminal-count compare. It is instantiated once and shared by ARM, RUN and COAST.
- Instantiated in the blind top-level, consuming the subir/bajar outputs of the position FSM.

Test Plan (bench uses DEAD_CYCLES = 4, MAX_RUN = 20):
- Reset with subir held 1, then release -> motor_en = 0 for 4 cycles (ARM), motor_dir = 1, then motor_en = 1; en_marcha = 1 from the first post-reset edge.
- Upward run, Ssup asserted after 10 RUN cycles -> motor_en falls on the next edge, 4 COAST cycles, then IDLE; fault = 0.
- Run with no limit hit for 20 cycles -> motor_en high exactly 20 cycles, then fault = 1, fault_code = 01. clr_fault = 1 while subir = 1 has no effect; clr_fault = 1 with no request -> IDLE, fault = 0.
- Reversal: RUN up, then bajar = 1 and subir = 0 -> COAST 4 cycles, IDLE, ARM 4 cycles with motor_dir = 0, then motor_en = 1. Verify motor_en is never 1 during the direction change.
- Ssup = Sinf = 1 during RUN -> FAULT with fault_code = 10 on the next edge, motor_en = 0. Same cycle as the timeout terminal count -> still code 10.
- Requests subir = bajar = 1, or bajar = 1 with Sinf already 1, in IDLE -> block stays IDLE, motor_en = 0, en_marcha = 0.
- Async reset pulsed mid-RUN between clock edges -> motor_en = 0 immediately, before the next Reloj edge.
